obf_key_loader: RTL

Serial configuration controller for the camouflaged-gate netlists: it receives a key bitstream, checks it, and drives the 2-bit select pairs (D_0..D_{2N-1}) of N obfuscation cells from a holding register. It sits between the test/key-provisioning port and the obfuscated combinational core. Select pairs stay stable at all times except on a single, validated update edge, and the configuration can be locked until the next reset.

---
 rtl/obf_key_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/obf_key_loader.sv
// Serial key loader for camouflaged-gate select pairs: shifts in a parity-protected
// key, validates it, and commits it to the select bus on a single update edge.
module obf_key_loader #(
    parameter  int NUM_CELLS = 5,
    localparam int KEY_W     = 2 * NUM_CELLS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             key_valid,
    input  logic             key_bit,
    output logic             key_ready,
    input  logic             lock_en,
    output logic [KEY_W-1:0] D,
    output logic             cfg_valid,
    output logic             busy,
    output logic             err,
    output logic             locked
);

    localparam int CNT_W = $clog2(KEY_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK,
        S_DONE,
        S_LOCKED
    } state_t;

    state_t           r_state;
    logic [KEY_W-1:0] r_shadow;
    logic [KEY_W-1:0] r_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_par;
    logic             r_lock_req;
    logic             r_key_ready;
    logic             r_busy;
    logic             r_cfg_valid;
    logic             r_err;
    logic             r_locked;

    // NOTE: all state, including the select bus, updates with non-blocking
    // assignments so every register samples pre-edge values regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shadow    <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_par       <= 1'b0;
            r_lock_req  <= 1'b0;
            r_key_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_valid <= 1'b0;
            r_err       <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_SHIFT;
                        r_cnt       <= '0;
                        r_shadow    <= '0;
                        r_par       <= 1'b0;
                        r_err       <= 1'b0;
                        r_key_ready <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        r_state     <= S_IDLE;
                        r_key_ready <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (key_valid) begin
                        // Running XOR covers data and parity bit; zero means even parity.
                        r_par <= r_par ^ key_bit;
                        if (r_cnt == CNT_W'(KEY_W)) begin
                            r_state     <= S_CHECK;
                            r_key_ready <= 1'b0;
                        end else begin
                            r_shadow <= {r_shadow[KEY_W-2:0], key_bit};
                            r_cnt    <= r_cnt + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    r_lock_req <= lock_en;
                    if (!r_par) begin
                        r_d         <= r_shadow;
                        r_cfg_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_cfg_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    if (r_lock_req) begin
                        r_state  <= S_LOCKED;
                        r_locked <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOCKED: begin
                    r_state <= S_LOCKED;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign key_ready = r_key_ready;
    assign D         = r_d;
    assign cfg_valid = r_cfg_valid;
    assign busy      = r_busy;
    assign err       = r_err;
    assign locked    = r_locked;

endmodule
